// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   - Load/store size codes seen by the extension stage (byte/half/word).
//   - Base byte-strobe patterns, shifted into lane position per access.
//   - Request-side FSM state encoding.
//   - Helpers for alignment check, strobe generation and store-lane shifting.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] DMEM_EXT_BYTE = 2'b00;
    localparam logic [1:0] DMEM_EXT_HALF = 2'b01;
    localparam logic [1:0] DMEM_EXT_WORD = 2'b10;

    localparam logic [3:0] DMEM_STRB_BYTE = 4'b0001;
    localparam logic [3:0] DMEM_STRB_HALF = 4'b0011;
    localparam logic [3:0] DMEM_STRB_WORD = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_e;

    // Any size code other than byte/half is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            DMEM_EXT_BYTE: is_misaligned = 1'b0;
            DMEM_EXT_HALF: is_misaligned = ofs[0];
            default:       is_misaligned = (ofs != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            DMEM_EXT_BYTE: lane_strobe = DMEM_STRB_BYTE << ofs;
            DMEM_EXT_HALF: lane_strobe = DMEM_STRB_HALF << ofs;
            default:       lane_strobe = DMEM_STRB_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] ofs);
        lane_data = wdata << {ofs, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and memory (slave).
//   bus_req_valid/ready : request handshake
//   bus_req_addr        : word-aligned byte address
//   bus_req_we          : write enable
//   bus_req_wstrb       : byte lane strobes
//   bus_req_wdata       : lane-shifted store data
//   bus_rsp_valid       : in-order response, always accepted
//   bus_rsp_rdata       : load data word
interface dmem_access_ctrl_if;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    modport master (
        output bus_req_valid,
        output bus_req_addr,
        output bus_req_we,
        output bus_req_wstrb,
        output bus_req_wdata,
        input  bus_req_ready,
        input  bus_rsp_valid,
        input  bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid,
        input  bus_req_addr,
        input  bus_req_we,
        input  bus_req_wstrb,
        input  bus_req_wdata,
        output bus_req_ready,
        output bus_rsp_valid,
        output bus_rsp_rdata
    );

endinterface

// File: rtl/dmem_access_ctrl_meta_fifo.sv
// In-order metadata queue for outstanding memory requests.
//   clk, rst_n         : clock, asynchronous active-low reset (clears pointers)
//   push, push_data    : enqueue (ignored when full unless popping the same cycle)
//   pop, pop_data      : dequeue head; pop_data shows the head combinationally
//   full, empty        : occupancy flags
module dmem_meta_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store request stage feeding the load-extension stage.
// Accepts LSU ops, traps misaligned accesses, issues word-aligned bus
// requests with byte strobes and lane-shifted store data, and pairs each
// in-order response with its queued metadata.
//   clk, rst_n          : clock, asynchronous active-low reset
//   lsu_*               : op from EX (valid/ready handshake)
//   misalign_valid/addr : registered one-cycle misaligned-access exception
//   bus                 : data-memory bus (master side)
//   dmem_out/shift/ext_size/ext_unsign, load_valid, load_rd : load result
//   store_done          : store ack pulse
//   busy                : request queued or in flight
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic            lsu_is_store,
    input  logic [31:0]     lsu_addr,
    input  logic [31:0]     lsu_wdata,
    input  logic [1:0]      lsu_size,
    input  logic            lsu_unsign,
    input  logic [RD_W-1:0] lsu_rd,
    output logic            misalign_valid,
    output logic [31:0]     misalign_addr,
    dmem_access_ctrl_if.master bus,
    output logic [31:0]     dmem_out,
    output logic [1:0]      dmem_shift,
    output logic [1:0]      dmem_ext_size,
    output logic            dmem_ext_unsign,
    output logic            load_valid,
    output logic [RD_W-1:0] load_rd,
    output logic            store_done,
    output logic            busy
);

    // Metadata layout: {shift, size, unsign, rd, is_store}
    localparam int META_W = 2 + 2 + 1 + RD_W + 1;

    req_state_e        state_q;
    req_state_e        state_d;
    logic              req_valid_p1;
    logic [31:0]       req_addr_p1;
    logic              req_we_p1;
    logic [3:0]        req_wstrb_p1;
    logic [31:0]       req_wdata_p1;
    logic              rsp_arm;

    logic              mis_p0;
    logic              rsp_vld_p0;
    logic              slot_free_p0;
    logic              bus_free_p0;
    logic              req_vld_p0;
    logic              mis_vld_p0;
    logic [META_W-1:0] meta_push_p0;
    logic [META_W-1:0] meta_head_p0;
    logic              fifo_full;
    logic              fifo_empty;

    logic [1:0]        head_shift;
    logic [1:0]        head_size;
    logic              head_unsign;
    logic [RD_W-1:0]   head_rd;
    logic              head_is_store;

    // ---- p0: accept decision from EX inputs and current bus/queue state ----
    assign mis_p0       = is_misaligned(lsu_size, lsu_addr[1:0]);
    // Responses in the first cycle after reset release are dropped via rsp_arm.
    assign rsp_vld_p0   = bus.bus_rsp_valid & rsp_arm & ~fifo_empty;
    // A same-cycle pop frees a slot for a push even when the queue is full.
    assign slot_free_p0 = ~fifo_full | rsp_vld_p0;
    assign bus_free_p0  = ~req_valid_p1 | bus.bus_req_ready;
    assign lsu_ready    = mis_p0 | (slot_free_p0 & bus_free_p0);
    assign req_vld_p0   = lsu_valid & ~mis_p0 & slot_free_p0 & bus_free_p0;
    assign mis_vld_p0   = lsu_valid & mis_p0;
    assign meta_push_p0 = {lsu_addr[1:0], lsu_size, lsu_unsign, lsu_rd, lsu_is_store};

    assign {head_shift, head_size, head_unsign, head_rd, head_is_store} = meta_head_p0;

    dmem_meta_fifo #(
        .W     (META_W),
        .DEPTH (OUTSTANDING)
    ) u_meta_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_vld_p0),
        .push_data (meta_push_p0),
        .pop       (rsp_vld_p0),
        .pop_data  (meta_head_p0),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---- p1: request FSM and registered bus outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_vld_p0) state_d = ST_REQ;
            ST_REQ:  if (bus.bus_req_ready && !req_vld_p0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_valid_p1 = (state_q == ST_REQ);
    end

    // Payload only loads on a new accept, so it holds while the bus stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_p1  <= '0;
            req_we_p1    <= 1'b0;
            req_wstrb_p1 <= '0;
            req_wdata_p1 <= '0;
        end else if (req_vld_p0) begin
            req_addr_p1  <= {lsu_addr[31:2], 2'b00};
            req_we_p1    <= lsu_is_store;
            req_wstrb_p1 <= lane_strobe(lsu_size, lsu_addr[1:0]);
            req_wdata_p1 <= lane_data(lsu_wdata, lsu_addr[1:0]);
        end
    end

    assign bus.bus_req_valid = req_valid_p1;
    assign bus.bus_req_addr  = req_addr_p1;
    assign bus.bus_req_we    = req_we_p1;
    assign bus.bus_req_wstrb = req_wstrb_p1;
    assign bus.bus_req_wdata = req_wdata_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_valid <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            misalign_valid <= mis_vld_p0;
            if (mis_vld_p0) misalign_addr <= lsu_addr;
        end
    end

    // ---- p1: response pairing with queued metadata ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_arm <= 1'b0;
        else        rsp_arm <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_valid      <= 1'b0;
            store_done      <= 1'b0;
            dmem_out        <= '0;
            dmem_shift      <= '0;
            dmem_ext_size   <= '0;
            dmem_ext_unsign <= 1'b0;
            load_rd         <= '0;
        end else begin
            load_valid <= rsp_vld_p0 & ~head_is_store;
            store_done <= rsp_vld_p0 & head_is_store;
            if (rsp_vld_p0 && !head_is_store) begin
                dmem_out        <= bus.bus_rsp_rdata;
                dmem_shift      <= head_shift;
                dmem_ext_size   <= head_size;
                dmem_ext_unsign <= head_unsign;
                load_rd         <= head_rd;
            end
        end
    end

    assign busy = ~fifo_empty | req_valid_p1;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expectations are queued when ops are
// accepted / responses are driven, and compared when the DUT produces them.
module tb_dmem_access_ctrl;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        is_store;
        logic [1:0]  shift;
        logic [1:0]  size;
        logic        unsign;
        logic [4:0]  rd;
        logic [31:0] rdata;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_is_store;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_unsign;
    logic [4:0]  lsu_rd;
    logic        misalign_valid;
    logic [31:0] misalign_addr;
    logic [31:0] dmem_out;
    logic [1:0]  dmem_shift;
    logic [1:0]  dmem_ext_size;
    logic        dmem_ext_unsign;
    logic        load_valid;
    logic [4:0]  load_rd;
    logic        store_done;
    logic        busy;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.OUTSTANDING(2), .RD_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_is_store    (lsu_is_store),
        .lsu_addr        (lsu_addr),
        .lsu_wdata       (lsu_wdata),
        .lsu_size        (lsu_size),
        .lsu_unsign      (lsu_unsign),
        .lsu_rd          (lsu_rd),
        .misalign_valid  (misalign_valid),
        .misalign_addr   (misalign_addr),
        .bus             (bus),
        .dmem_out        (dmem_out),
        .dmem_shift      (dmem_shift),
        .dmem_ext_size   (dmem_ext_size),
        .dmem_ext_unsign (dmem_ext_unsign),
        .load_valid      (load_valid),
        .load_rd         (load_rd),
        .store_done      (store_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic orphan_ok = 1'b0;

    req_t        exp_req[$];
    out_t        exp_meta[$];
    out_t        exp_out[$];
    logic [31:0] exp_mis[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic tb_mis(input logic [1:0] size, input logic [1:0] a);
        if (size == SZ_B) return 1'b0;
        if (size == SZ_H) return a[0];
        return a != 2'b00;
    endfunction

    function automatic logic [3:0] tb_strb(input logic [1:0] size, input logic [1:0] a);
        if (size == SZ_W) return 4'b1111;
        if (size == SZ_H) return (a == 2'd2) ? 4'b1100 : 4'b0011;
        case (a)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] tb_lane(input logic [31:0] w, input logic [1:0] a);
        case (a)
            2'd0:    return w;
            2'd1:    return {w[23:0], 8'h00};
            2'd2:    return {w[15:0], 16'h0000};
            default: return {w[7:0], 24'h000000};
        endcase
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : mon
        req_t        r;
        out_t        o;
        logic [31:0] ma;
        if (rst_n === 1'b1) begin
            if (exp_out.size() > 0) begin
                o = exp_out.pop_front();
                chk("store_done", store_done, o.is_store);
                chk("load_valid", load_valid, !o.is_store);
                if (!o.is_store) begin
                    chk("dmem_out", dmem_out, o.rdata);
                    chk("dmem_shift", dmem_shift, o.shift);
                    chk("dmem_ext_size", dmem_ext_size, o.size);
                    chk("dmem_ext_unsign", dmem_ext_unsign, o.unsign);
                    chk("load_rd", load_rd, o.rd);
                end
            end else if (load_valid || store_done) begin
                chk("unexpected_rsp_out", {load_valid, store_done}, 0);
            end

            if (exp_mis.size() > 0) begin
                ma = exp_mis.pop_front();
                chk("misalign_valid", misalign_valid, 1);
                chk("misalign_addr", misalign_addr, ma);
            end else if (misalign_valid) begin
                chk("unexpected_misalign", misalign_valid, 0);
            end

            if (bus.bus_req_valid && bus.bus_req_ready) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_bus_req", 1, 0);
                end else begin
                    r = exp_req.pop_front();
                    chk("bus_req_addr", bus.bus_req_addr, r.addr);
                    chk("bus_req_we", bus.bus_req_we, r.we);
                    chk("bus_req_wstrb", bus.bus_req_wstrb, r.strb);
                    chk("bus_req_wdata", bus.bus_req_wdata, r.wdata);
                end
            end

            if (lsu_valid && lsu_ready) begin
                if (tb_mis(lsu_size, lsu_addr[1:0])) begin
                    exp_mis.push_back(lsu_addr);
                end else begin
                    r.addr  = {lsu_addr[31:2], 2'b00};
                    r.we    = lsu_is_store;
                    r.strb  = tb_strb(lsu_size, lsu_addr[1:0]);
                    r.wdata = tb_lane(lsu_wdata, lsu_addr[1:0]);
                    exp_req.push_back(r);
                    o.is_store = lsu_is_store;
                    o.shift    = lsu_addr[1:0];
                    o.size     = lsu_size;
                    o.unsign   = lsu_unsign;
                    o.rd       = lsu_rd;
                    o.rdata    = '0;
                    exp_meta.push_back(o);
                end
            end

            if (bus.bus_rsp_valid && !orphan_ok) begin
                if (exp_meta.size() == 0) begin
                    chk("rsp_to_empty_queue", 1, 0);
                end else begin
                    o = exp_meta.pop_front();
                    o.rdata = bus.bus_rsp_rdata;
                    exp_out.push_back(o);
                end
            end
        end
    end

    task automatic drive(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd);
        lsu_valid    = 1'b1;
        lsu_is_store = st;
        lsu_addr     = addr;
        lsu_wdata    = wdata;
        lsu_size     = size;
        lsu_unsign   = uns;
        lsu_rd       = rd;
    endtask

    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lsu_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd);
        drive(st, addr, wdata, size, uns, rd);
        wait_accept();
    endtask

    task automatic rsp(input logic [31:0] data);
        bus.bus_rsp_valid = 1'b1;
        bus.bus_rsp_rdata = data;
        @(posedge clk);
        #1;
        bus.bus_rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        lsu_valid         = 1'b0;
        lsu_is_store      = 1'b0;
        lsu_addr          = '0;
        lsu_wdata         = '0;
        lsu_size          = SZ_W;
        lsu_unsign        = 1'b0;
        lsu_rd            = '0;
        bus.bus_req_ready = 1'b1;
        bus.bus_rsp_valid = 1'b0;
        bus.bus_rsp_rdata = '0;

        // Reset state
        #12;
        chk("rst_bus_req_valid", bus.bus_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_misalign_valid", misalign_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Byte load at 0x1003, response one cycle after the request
        issue(1'b0, 32'h0000_1003, 32'h0, SZ_B, 1'b0, 5'd7);
        chk("t1_req_valid", bus.bus_req_valid, 1);
        chk("t1_req_addr", bus.bus_req_addr, 32'h0000_1000);
        chk("t1_req_wstrb", bus.bus_req_wstrb, 4'b1000);
        @(posedge clk);
        #1;
        rsp(32'h80AA_55CC);
        repeat (2) @(posedge clk);
        #1;

        // Half store at 0x2002
        issue(1'b1, 32'h0000_2002, 32'h0000_BEEF, SZ_H, 1'b0, 5'd0);
        chk("t2_req_wdata", bus.bus_req_wdata, 32'hBEEF_0000);
        chk("t2_req_wstrb", bus.bus_req_wstrb, 4'b1100);
        chk("t2_req_we", bus.bus_req_we, 1);
        @(posedge clk);
        #1;
        rsp(32'hDEAD_0000);
        @(negedge clk);
        chk("t2_store_done", store_done, 1);
        chk("t2_no_load_valid", load_valid, 0);
        @(posedge clk);
        #1;

        // Misaligned word load at 0x3001
        issue(1'b0, 32'h0000_3001, 32'h0, SZ_W, 1'b0, 5'd2);
        @(negedge clk);
        chk("t3_no_bus_req", bus.bus_req_valid, 0);
        chk("t3_not_busy", busy, 0);
        @(posedge clk);
        #1;

        // Bus stall with a second op pending
        bus.bus_req_ready = 1'b0;
        issue(1'b0, 32'h0000_4000, 32'h0, SZ_W, 1'b0, 5'd1);
        drive(1'b0, 32'h0000_4101, 32'h0, SZ_H, 1'b0, 5'd6);
        @(negedge clk);
        chk("t4_mis_ready", lsu_ready, 1);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h0000_4006, 32'h0000_005A, SZ_B, 1'b0, 5'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_ready", lsu_ready, 0);
            chk("t4_stall_valid", bus.bus_req_valid, 1);
            chk("t4_stall_addr", bus.bus_req_addr, 32'h0000_4000);
            chk("t4_stall_we", bus.bus_req_we, 0);
            chk("t4_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        bus.bus_req_ready = 1'b1;
        wait_accept();
        chk("t4_second_addr", bus.bus_req_addr, 32'h0000_4004);
        chk("t4_second_wdata", bus.bus_req_wdata, 32'h005A_0000);
        rsp(32'h1111_2222);
        rsp(32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Three back-to-back loads, queue depth 2
        issue(1'b0, 32'h0000_5001, 32'h0, SZ_B, 1'b1, 5'd3);
        issue(1'b0, 32'h0000_5002, 32'h0, SZ_H, 1'b0, 5'd4);
        drive(1'b0, 32'h0000_5004, 32'h0, SZ_W, 1'b0, 5'd5);
        repeat (2) begin
            @(negedge clk);
            chk("t5_full_ready", lsu_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.bus_rsp_valid = 1'b1;
        bus.bus_rsp_rdata = 32'hA1B2_C3D4;
        @(negedge clk);
        chk("t5_ready_on_pop", lsu_ready, 1);
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        chk("t5_third_valid", bus.bus_req_valid, 1);
        chk("t5_third_addr", bus.bus_req_addr, 32'h0000_5004);
        bus.bus_rsp_rdata = 32'h5566_7788;
        @(posedge clk);
        #1;
        bus.bus_rsp_rdata = 32'h99AA_BBCC;
        @(posedge clk);
        #1;
        bus.bus_rsp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idle_busy", busy, 0);

        // Reset with two requests in flight
        issue(1'b0, 32'h0000_7000, 32'h0, SZ_W, 1'b0, 5'd9);
        issue(1'b0, 32'h0000_7002, 32'h0, SZ_H, 1'b0, 5'd10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("r_bus_req_valid", bus.bus_req_valid, 0);
        chk("r_bus_req_addr", bus.bus_req_addr, 0);
        chk("r_bus_req_we", bus.bus_req_we, 0);
        chk("r_bus_req_wstrb", bus.bus_req_wstrb, 0);
        chk("r_bus_req_wdata", bus.bus_req_wdata, 0);
        chk("r_misalign_valid", misalign_valid, 0);
        chk("r_misalign_addr", misalign_addr, 0);
        chk("r_load_valid", load_valid, 0);
        chk("r_store_done", store_done, 0);
        chk("r_dmem_out", dmem_out, 0);
        chk("r_dmem_shift", dmem_shift, 0);
        chk("r_dmem_ext_size", dmem_ext_size, 0);
        chk("r_dmem_ext_unsign", dmem_ext_unsign, 0);
        chk("r_load_rd", load_rd, 0);
        chk("r_busy", busy, 0);
        exp_req.delete();
        exp_meta.delete();
        exp_out.delete();
        exp_mis.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        orphan_ok = 1'b1;
        bus.bus_rsp_valid = 1'b1;
        bus.bus_rsp_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.bus_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("r_orphan_load_valid", load_valid, 0);
            chk("r_orphan_store_done", store_done, 0);
        end
        orphan_ok = 1'b0;
        chk("r_after_busy", busy, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("left_exp_req", exp_req.size(), 0);
        chk("left_exp_meta", exp_meta.size(), 0);
        chk("left_exp_out", exp_out.size(), 0);
        chk("left_exp_mis", exp_mis.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
